keypad_press_encoder: RTL

Front-end for the four-button keypad that drives `digital_lock`. It synchronizes and debounces the raw push-buttons and encodes each key-down episode into one 4-bit code. The code is presented on `btn`, with a single-cycle `is_a_key_pressed` strobe, so the lock FSM advances exactly once per physical press. It sits between the board button pins and the `btn`/`is_a_key_pressed` inputs of the lock.

---
 rtl/keypad_press_encoder.sv | 95 +++++++++
 1 files changed

// File: rtl/keypad_press_encoder.sv
// Four-button keypad front-end: synchronizes and debounces raw buttons, then emits one code
// plus a single-cycle strobe per key-down episode.
module keypad_press_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn,
  output logic       is_a_key_pressed,
  output logic       key_down
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StHeld} state_e;

  logic [3:0]      sync1_q, sync_q;
  logic [3:0]      deb_q, deb_d, deb_prev_q;
  logic [CntW-1:0] cnt_q [4];
  logic [CntW-1:0] cnt_d [4];
  logic [3:0]      rise;
  state_e          state_q;
  logic [3:0]      btn_q;
  logic            strobe_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync_q  <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync_q  <= sync1_q;
    end
  end

  // Any return of sync to the debounced level clears the count: no partial credit.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      if (sync_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          deb_d[i] = sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign rise = deb_q & ~deb_prev_q;

  // Only the first rise of an episode is emitted; HELD waits for all buttons released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      btn_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|rise) begin
            btn_q    <= rise;
            strobe_q <= 1'b1;
            state_q  <= StHeld;
          end
        end
        StHeld: begin
          if (deb_q == 4'b0000) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign btn              = btn_q;
  assign is_a_key_pressed = strobe_q;
  assign key_down         = |deb_q;

endmodule
